apb4_completer_mem: RTL and testbench

- Parametrised APB4 completer (slave) with a byte-addressable word memory behind it, programmable wait states and error generation.
- It is the APB3 bus generalised to APB4: adds PSTRB and PPROT, configurable data width and depth, run-time wait-state insertion, and PSLVERR sources.
- It sits behind the debug-port APB as a reference/scratch target for the APB master agents, and as a DUT-side model in block benches.

---
 rtl/apb4_pkg.sv | 28 ++
 rtl/apb4_byte_mem.sv | 28 ++
 rtl/apb4_completer_mem.sv | 152 +++++++++++++++
 tb/tb_apb4_completer_mem.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_pkg.sv
// Shared types and helpers for the APB4 completer memory.
package apb4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte lanes on a bus of the given width.
  function automatic int strb_w(input int data_width);
    return data_width / 8;
  endfunction

  // Number of byte-offset bits below the word index.
  function automatic int lsb_w(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Address faults: word index beyond the array, or a byte offset inside the word.
  function automatic logic addr_err(input logic [31:0] paddr, input int unsigned lsb,
                                    input int unsigned depth);
    logic [31:0] mask;
    mask = (32'd1 << lsb) - 32'd1;
    return ((paddr >> lsb) >= depth) || ((paddr & mask) != 32'd0);
  endfunction

endpackage

// File: rtl/apb4_byte_mem.sv
// Word array with an asynchronous read port and a byte-enabled write port; contents are not reset.
module apb4_byte_mem #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        we_i,
  input  logic [$clog2(DEPTH)-1:0]    waddr_i,
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  input  logic [DATA_WIDTH/8-1:0]     be_i,
  input  logic [$clog2(DEPTH)-1:0]    raddr_i,
  output logic [DATA_WIDTH-1:0]       rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Update only the byte lanes whose enable is set.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb4_completer_mem.sv
// APB4 completer fronting a byte-addressable word memory, with programmable
// wait states, error responses and transfer/error counters.
module apb4_completer_mem
  import apb4_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int MAX_WAIT   = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  input  logic [3:0]              wait_cfg,
  input  logic                    priv_only,
  output logic [15:0]             xfer_cnt,
  output logic [15:0]             err_cnt
);

  localparam int STRB_W = strb_w(DATA_WIDTH);
  localparam int LSB    = lsb_w(DATA_WIDTH);
  localparam int MAW    = $clog2(DEPTH);
  localparam logic [3:0] MAXW = (MAX_WAIT >= 15) ? 4'd15 : 4'(MAX_WAIT);

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [15:0]           xfer_cnt_q;
  logic [15:0]           err_cnt_q;

  // Setup-phase snapshot, held for the whole access phase.
  logic [MAW-1:0]        addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic                  err_q;

  logic                  setup;
  logic                  setup_err;
  logic [3:0]            wait_eff;
  logic                  complete;
  logic                  mem_we;
  logic [MAW-1:0]        mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  unused_prot;

  assign unused_prot = ^pprot[2:1];

  assign setup     = (state_q == IDLE) && psel && !penable;
  assign setup_err = addr_err(32'(paddr), LSB, DEPTH) || (priv_only && !pprot[0]);
  assign wait_eff  = (wait_cfg > MAXW) ? MAXW : wait_cfg;
  assign complete  = (state_q == DONE) && psel && penable && pready_q;
  assign mem_we    = complete && write_q && !err_q;
  // With zero wait states the read happens on the setup edge, before addr_q is loaded.
  assign mem_raddr = (state_q == IDLE) ? paddr[LSB +: MAW] : addr_q;

  apb4_byte_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .be_i    (strb_q),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  // Capture the transfer attributes in the setup cycle.
  always_ff @(posedge clk) begin
    if (setup) begin
      addr_q  <= paddr[LSB +: MAW];
      write_q <= pwrite;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
      err_q   <= setup_err;
    end
  end

  // Transfer FSM with registered response outputs and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      xfer_cnt_q <= 16'd0;
      err_cnt_q  <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (setup) begin
            if (wait_eff == 4'd0) begin
              state_q   <= DONE;
              pready_q  <= 1'b1;
              pslverr_q <= setup_err;
              prdata_q  <= setup_err ? '0 : mem_rdata;
            end else begin
              state_q <= WAIT;
              cnt_q   <= wait_eff - 4'd1;
            end
          end
        end
        WAIT: begin
          if (!psel) begin
            state_q <= IDLE;
          end else if (cnt_q == 4'd0) begin
            state_q   <= DONE;
            pready_q  <= 1'b1;
            pslverr_q <= err_q;
            prdata_q  <= err_q ? '0 : mem_rdata;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (!psel || complete) begin
            state_q   <= IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
          end
          if (complete) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
            if (err_q && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prdata   = prdata_q;
  assign pready   = pready_q;
  assign pslverr  = pslverr_q;
  assign xfer_cnt = xfer_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_apb4_completer_mem.sv
// Bench for apb4_completer_mem: bus driver, reference memory and expectation queue.
module tb_apb4_completer_mem;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;
  logic [3:0]    wait_cfg;
  logic          priv_only;
  logic [15:0]   xfer_cnt, err_cnt;

  always #5 clk = ~clk;

  apb4_completer_mem #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .MAX_WAIT   (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pprot     (pprot),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .wait_cfg  (wait_cfg),
    .priv_only (priv_only),
    .xfer_cnt  (xfer_cnt),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic          chk_data;
    logic [DW-1:0] data;
    logic          err;
    int            cycles;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mem_m [DEPTH];
  int            tests = 0;
  int            fails = 0;
  int            xfer_m = 0;
  int            err_m = 0;

  function automatic logic model_err(input logic [AW-1:0] a, input logic [2:0] pr);
    return (a[1:0] != 2'b00) || ((32'(a) >> 2) >= DEPTH) || (priv_only && !pr[0]);
  endfunction

  // Compute the expected response of one transfer and advance the reference state.
  task automatic sb_push(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                         input logic [3:0] st, input logic [2:0] pr, input logic [3:0] wc);
    exp_t e;
    int   idx;
    e.err      = model_err(a, pr);
    e.chk_data = !w;
    e.cycles   = int'(wc) + 1;
    idx        = int'(32'(a) >> 2);
    if (w || e.err) e.data = '0;
    else            e.data = mem_m[idx];
    if (w && !e.err) begin
      for (int b = 0; b < 4; b++) if (st[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
    end
    xfer_m++;
    if (e.err) err_m++;
    sb.push_back(e);
  endtask

  // One APB transfer; scrambles addr/data/wait_cfg during the access phase.
  task automatic apb_xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                          input logic [3:0] st, input logic [2:0] pr, input logic [3:0] wc,
                          output logic [DW-1:0] rd, output logic er, output int cyc);
    paddr = a; pwrite = w; pwdata = wd; pstrb = st; pprot = pr; wait_cfg = wc;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable  = 1'b1;
    paddr    = AW'($urandom);
    pwdata   = $urandom;
    wait_cfg = 4'($urandom);
    cyc = 1;
    while (pready !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    rd = prdata;
    er = pslverr;
    if (pready !== 1'b1) cyc = 999;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset;
    tests++; if (pready !== 1'b0) begin fails++; $display("FAIL reset_pready got %0b want 0", pready); end
    tests++; if (pslverr !== 1'b0) begin fails++; $display("FAIL reset_pslverr got %0b want 0", pslverr); end
    tests++; if (prdata !== 32'h0) begin fails++; $display("FAIL reset_prdata got %h want 0", prdata); end
    tests++; if (xfer_cnt !== 16'h0) begin fails++; $display("FAIL reset_xfer_cnt got %0d want 0", xfer_cnt); end
    tests++; if (err_cnt !== 16'h0) begin fails++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
  endtask

  task automatic test_write_read;
    logic [DW-1:0] rd; logic er; int cyc; exp_t e;
    sb_push(12'h010, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, 4'd0);
    apb_xfer(12'h010, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, 4'd0, rd, er, cyc);
    e = sb.pop_front();
    tests++; if (er !== e.err) begin fails++; $display("FAIL wr_err got %0b want %0b", er, e.err); end
    tests++; if (cyc !== e.cycles) begin fails++; $display("FAIL wr_cycles got %0d want %0d", cyc, e.cycles); end
    sb_push(12'h010, 1'b0, 32'h0, 4'hF, 3'b001, 4'd0);
    apb_xfer(12'h010, 1'b0, 32'h0, 4'hF, 3'b001, 4'd0, rd, er, cyc);
    e = sb.pop_front();
    tests++; if (rd !== e.data) begin fails++; $display("FAIL rd_data got %h want %h", rd, e.data); end
    tests++; if (er !== e.err) begin fails++; $display("FAIL rd_err got %0b want %0b", er, e.err); end
    tests++; if (cyc !== e.cycles) begin fails++; $display("FAIL rd_cycles got %0d want %0d", cyc, e.cycles); end
    tests++; if (xfer_cnt !== 16'(xfer_m)) begin fails++; $display("FAIL wr_rd_xfer_cnt got %0d want %0d", xfer_cnt, xfer_m); end
    tests++; if (pready !== 1'b0 || prdata !== 32'h0) begin
      fails++; $display("FAIL idle_outputs got pready=%0b prdata=%h want 0/0", pready, prdata);
    end
  endtask

  task automatic test_strobes;
    logic [DW-1:0] rd; logic er; int cyc; exp_t e;
    logic [AW-1:0] ad [4] = '{12'h020, 12'h020, 12'h020, 12'h020};
    logic          wr [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [DW-1:0] wd [4] = '{32'hFFFFFFFF, 32'h11223344, 32'h0, 32'h99999999};
    logic [3:0]    st [4] = '{4'hF, 4'b0101, 4'hF, 4'h0};
    for (int i = 0; i < 4; i++) begin
      sb_push(ad[i], wr[i], wd[i], st[i], 3'b001, 4'd0);
      apb_xfer(ad[i], wr[i], wd[i], st[i], 3'b001, 4'd0, rd, er, cyc);
      e = sb.pop_front();
      tests++; if (er !== e.err) begin fails++; $display("FAIL strb_err[%0d] got %0b want %0b", i, er, e.err); end
      if (e.chk_data) begin
        tests++; if (rd !== e.data) begin fails++; $display("FAIL strb_data[%0d] got %h want %h", i, rd, e.data); end
      end
    end
    sb_push(12'h020, 1'b0, 32'h0, 4'h0, 3'b001, 4'd0);
    apb_xfer(12'h020, 1'b0, 32'h0, 4'h0, 3'b001, 4'd0, rd, er, cyc);
    e = sb.pop_front();
    tests++; if (rd !== e.data) begin fails++; $display("FAIL strb_zero_data got %h want %h", rd, e.data); end
  endtask

  task automatic test_wait_states;
    logic [DW-1:0] rd; logic er; int cyc; exp_t e;
    logic [3:0] wc [3] = '{4'd3, 4'd15, 4'd1};
    logic       wr [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      sb_push(12'h030, wr[i], 32'hCAFEF00D, 4'hF, 3'b001, wc[i]);
      apb_xfer(12'h030, wr[i], 32'hCAFEF00D, 4'hF, 3'b001, wc[i], rd, er, cyc);
      e = sb.pop_front();
      tests++; if (cyc !== e.cycles) begin fails++; $display("FAIL wait_cycles[%0d] got %0d want %0d", i, cyc, e.cycles); end
      if (e.chk_data) begin
        tests++; if (rd !== e.data) begin fails++; $display("FAIL wait_data[%0d] got %h want %h", i, rd, e.data); end
      end
    end
  endtask

  task automatic test_errors;
    logic [DW-1:0] rd; logic er; int cyc; exp_t e;
    logic [AW-1:0] ad [4] = '{12'h400, 12'h012, 12'h010, 12'h010};
    logic          wr [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic          po [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]    pr [4] = '{3'b001, 3'b001, 3'b001, 3'b000};
    for (int i = 0; i < 4; i++) begin
      priv_only = po[i];
      sb_push(ad[i], wr[i], 32'h55AA55AA, 4'hF, pr[i], 4'd1);
      apb_xfer(ad[i], wr[i], 32'h55AA55AA, 4'hF, pr[i], 4'd1, rd, er, cyc);
      e = sb.pop_front();
      tests++; if (er !== e.err) begin fails++; $display("FAIL err_flag[%0d] got %0b want %0b", i, er, e.err); end
      if (e.chk_data) begin
        tests++; if (rd !== e.data) begin fails++; $display("FAIL err_data[%0d] got %h want %h", i, rd, e.data); end
      end
    end
    priv_only = 1'b0;
    tests++; if (err_cnt !== 16'(err_m)) begin fails++; $display("FAIL err_cnt got %0d want %0d", err_cnt, err_m); end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] rd; logic er; int cyc; exp_t e; int start;
    start = xfer_m;
    for (int i = 0; i < 4; i++) begin
      sb_push(AW'(12'h100 + 4*i), 1'b1, 32'h1000 + i, 4'hF, 3'b001, 4'd0);
      apb_xfer(AW'(12'h100 + 4*i), 1'b1, 32'h1000 + i, 4'hF, 3'b001, 4'd0, rd, er, cyc);
      e = sb.pop_front();
      tests++; if (cyc !== e.cycles) begin fails++; $display("FAIL b2b_cycles[%0d] got %0d want %0d", i, cyc, e.cycles); end
    end
    tests++; if (xfer_cnt !== 16'(start + 4)) begin fails++; $display("FAIL b2b_xfer_cnt got %0d want %0d", xfer_cnt, start + 4); end
    sb_push(12'h10C, 1'b0, 32'h0, 4'hF, 3'b001, 4'd0);
    apb_xfer(12'h10C, 1'b0, 32'h0, 4'hF, 3'b001, 4'd0, rd, er, cyc);
    e = sb.pop_front();
    tests++; if (rd !== e.data) begin fails++; $display("FAIL b2b_readback got %h want %h", rd, e.data); end
  endtask

  task automatic test_abort;
    logic [DW-1:0] rd; logic er; int cyc; exp_t e; int bad;
    paddr = 12'h030; pwrite = 1'b1; pwdata = 32'hA5A5A5A5; pstrb = 4'hF; pprot = 3'b001;
    wait_cfg = 4'd5; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    psel = 1'b0; penable = 1'b0;
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (pready !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL abort_pready got %0d high cycles want 0", bad); end
    tests++; if (xfer_cnt !== 16'(xfer_m)) begin fails++; $display("FAIL abort_xfer_cnt got %0d want %0d", xfer_cnt, xfer_m); end
    sb_push(12'h030, 1'b0, 32'h0, 4'hF, 3'b001, 4'd0);
    apb_xfer(12'h030, 1'b0, 32'h0, 4'hF, 3'b001, 4'd0, rd, er, cyc);
    e = sb.pop_front();
    tests++; if (rd !== e.data) begin fails++; $display("FAIL abort_mem got %h want %h", rd, e.data); end
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] rd; logic er; int cyc; exp_t e;
    paddr = 12'h100; pwrite = 1'b1; pwdata = 32'h0BADF00D; pstrb = 4'hF; pprot = 3'b001;
    wait_cfg = 4'd5; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    xfer_m = 0; err_m = 0;
    #1;
    tests++; if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
      fails++; $display("FAIL rstmid_outputs got pready=%0b pslverr=%0b prdata=%h want 0", pready, pslverr, prdata);
    end
    tests++; if (xfer_cnt !== 16'h0 || err_cnt !== 16'h0) begin
      fails++; $display("FAIL rstmid_counters got xfer=%0d err=%0d want 0/0", xfer_cnt, err_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    sb_push(12'h100, 1'b0, 32'h0, 4'hF, 3'b001, 4'd2);
    apb_xfer(12'h100, 1'b0, 32'h0, 4'hF, 3'b001, 4'd2, rd, er, cyc);
    e = sb.pop_front();
    tests++; if (rd !== e.data) begin fails++; $display("FAIL rstmid_mem got %h want %h", rd, e.data); end
    tests++; if (cyc !== e.cycles) begin fails++; $display("FAIL rstmid_cycles got %0d want %0d", cyc, e.cycles); end
    tests++; if (xfer_cnt !== 16'(xfer_m)) begin fails++; $display("FAIL rstmid_xfer_cnt got %0d want %0d", xfer_cnt, xfer_m); end
  endtask

  initial begin
    rst = 1'b1; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
    pstrb = '0; pprot = 3'b001; wait_cfg = 4'd0; priv_only = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    test_write_read;
    test_strobes;
    test_wait_states;
    test_errors;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
